// File: rtl/oled_spi_tx_pkg.sv
// Shared types and constants for the SSD1306 OLED SPI transmitter.
// Holds the controller state encoding and common panel command bytes.
package oled_pkg;

  typedef enum logic [1:0] {
    RST_LOW  = 2'd0,
    RST_WAIT = 2'd1,
    IDLE     = 2'd2,
    SHIFT    = 2'd3
  } oled_state_e;

  localparam logic [7:0] DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] DISPLAY_ON  = 8'hAF;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/oled_spi_tx_if.sv
// Byte stream handshake into the OLED transmitter (valid/ready, MSB-first byte + D/C flag).
interface oled_spi_tx_if;
  logic [7:0] s_data;
  logic       s_dc;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_dc, output s_valid, input s_ready);
  modport slave  (input s_data, input s_dc, input s_valid, output s_ready);
endinterface

// File: rtl/oled_tick_gen.sv
// Divide-by-CLK_DIV phase tick generator; a restart pulse realigns the phase
// so the first tick lands exactly CLK_DIV cycles after the restart.
module oled_tick_gen #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Phase counter, cleared on restart and at each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = !i_restart && (r_cnt == LAST);

endmodule

// File: rtl/oled_spi_tx.sv
// SPI mode-0 byte transmitter for the SSD1306 OLED, with optional panel
// power-up reset sequence enabled by OLED_SPI_TX_PWRUP_RST_EN.
module oled_spi_tx #(
  parameter int CLK_DIV         = 4,
  parameter int RST_LOW_CYCLES  = 1000,
  parameter int RST_WAIT_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  oled_spi_tx_if.slave  s,
  output logic          busy,
  output logic          init_done,
  output logic          oled_nrst,
  output logic          oled_dc,
  output logic          oled_sclk,
  output logic          oled_sdin
);

  import oled_pkg::*;

  localparam int unsigned MAXC = max3(CLK_DIV, RST_LOW_CYCLES, RST_WAIT_CYCLES);
  localparam int          CW   = $clog2(MAXC) + 1;

`ifdef OLED_SPI_TX_PWRUP_RST_EN
  localparam logic [CW-1:0] LOW_LAST    = CW'(RST_LOW_CYCLES);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(RST_WAIT_CYCLES - 1);
  localparam oled_state_e   RESET_STATE = RST_LOW;
`else
  localparam oled_state_e   RESET_STATE = IDLE;
`endif

  oled_state_e r_state, w_state_nx;
`ifdef OLED_SPI_TX_PWRUP_RST_EN
  logic [CW-1:0] r_cnt, w_cnt_nx;
`endif
  logic [2:0] r_bit_cnt, w_bit_cnt_nx;
  logic [7:0] r_shreg, w_shreg_nx;
  logic r_sclk, w_sclk_nx;
  logic r_sdin, w_sdin_nx;
  logic r_dc, w_dc_nx;
  logic r_nrst, w_nrst_nx;
  logic r_ready, w_ready_nx;
  logic r_init_done, w_init_done_nx;
  logic r_busy, w_busy_nx;
  logic w_accept;
  logic w_restart;
  logic w_tick;

  oled_tick_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CW)
  ) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  assign w_accept = s.s_valid && r_ready && (r_state == IDLE);

  // Next-state and next-output logic for the power-up / idle / shift controller
  always_comb begin
    w_state_nx     = r_state;
`ifdef OLED_SPI_TX_PWRUP_RST_EN
    w_cnt_nx       = r_cnt;
    w_nrst_nx      = r_nrst;
    w_init_done_nx = r_init_done;
`else
    w_nrst_nx      = 1'b1;
    w_init_done_nx = 1'b1;
`endif
    w_bit_cnt_nx   = r_bit_cnt;
    w_shreg_nx     = r_shreg;
    w_sclk_nx      = r_sclk;
    w_sdin_nx      = r_sdin;
    w_dc_nx        = r_dc;
    w_restart      = 1'b0;

    case (r_state)
`ifdef OLED_SPI_TX_PWRUP_RST_EN
      RST_LOW: begin
        w_nrst_nx = 1'b0;
        w_sclk_nx = 1'b0;
        if (r_cnt == LOW_LAST) begin
          w_state_nx = RST_WAIT;
          w_cnt_nx   = '0;
          w_nrst_nx  = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt + CW'(1);
        end
      end
      RST_WAIT: begin
        w_sclk_nx = 1'b0;
        if (r_cnt == WAIT_LAST) begin
          w_state_nx     = IDLE;
          w_cnt_nx       = '0;
          w_init_done_nx = 1'b1;
        end else begin
          w_cnt_nx       = r_cnt + CW'(1);
        end
      end
`endif
      IDLE: begin
        w_sclk_nx = 1'b0;
        if (w_accept) begin
          w_state_nx   = SHIFT;
          w_shreg_nx   = {s.s_data[6:0], 1'b0};
          w_sdin_nx    = s.s_data[7];
          w_dc_nx      = s.s_dc;
          w_bit_cnt_nx = 3'd0;
          w_restart    = 1'b1;
        end else begin
          w_state_nx   = IDLE;
        end
      end
      SHIFT: begin
        if (w_tick) begin
          if (!r_sclk) begin
            w_sclk_nx = 1'b1;
          end else begin
            // Falling edge closes a bit; the 3-bit counter wraps to 0 after bit 7
            w_sclk_nx    = 1'b0;
            w_bit_cnt_nx = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              w_state_nx = IDLE;
            end else begin
              w_sdin_nx  = r_shreg[7];
              w_shreg_nx = {r_shreg[6:0], 1'b0};
            end
          end
        end else begin
          w_sclk_nx = r_sclk;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_sclk_nx  = 1'b0;
      end
    endcase

    w_ready_nx = (w_state_nx == IDLE);
    w_busy_nx  = (w_state_nx != IDLE);
  end

  // State and registered panel/handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_STATE;
`ifdef OLED_SPI_TX_PWRUP_RST_EN
      r_cnt       <= '0;
`endif
      r_bit_cnt   <= 3'd0;
      r_shreg     <= 8'd0;
      r_sclk      <= 1'b0;
      r_sdin      <= 1'b0;
      r_dc        <= 1'b0;
      r_nrst      <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
`ifdef OLED_SPI_TX_PWRUP_RST_EN
      r_cnt       <= w_cnt_nx;
`endif
      r_bit_cnt   <= w_bit_cnt_nx;
      r_shreg     <= w_shreg_nx;
      r_sclk      <= w_sclk_nx;
      r_sdin      <= w_sdin_nx;
      r_dc        <= w_dc_nx;
      r_nrst      <= w_nrst_nx;
      r_ready     <= w_ready_nx;
      r_init_done <= w_init_done_nx;
      r_busy      <= w_busy_nx;
    end
  end

  assign s.s_ready = r_ready;
  assign busy      = r_busy;
  assign init_done = r_init_done;
  assign oled_nrst = r_nrst;
  assign oled_dc   = r_dc;
  assign oled_sclk = r_sclk;
  assign oled_sdin = r_sdin;

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx: power-up sequence, byte table, back-to-back
// bytes, hold-off during init and mid-byte reset.
module tb_oled_spi_tx;
  import oled_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int RL      = 8;
  localparam int RW      = 8;
`ifdef OLED_SPI_TX_PWRUP_RST_EN
  localparam int NRST_EDGE = RL + 1;
  localparam int INIT_EDGE = RL + RW + 1;
`else
  localparam int NRST_EDGE = 1;
  localparam int INIT_EDGE = 1;
`endif

  logic clk;
  logic rst_n;
  logic busy, init_done, oled_nrst, oled_dc, oled_sclk, oled_sdin;

  oled_spi_tx_if bus();

  oled_spi_tx #(
    .CLK_DIV         (CLK_DIV),
    .RST_LOW_CYCLES  (RL),
    .RST_WAIT_CYCLES (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (bus.slave),
    .busy      (busy),
    .init_done (init_done),
    .oled_nrst (oled_nrst),
    .oled_dc   (oled_dc),
    .oled_sclk (oled_sclk),
    .oled_sdin (oled_sdin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_bad = 0;

  // SCLK edge monitor sampled on the falling clk edge
  logic rise_sdin [256];
  logic rise_dc   [256];
  int   rise_cyc  [256];
  int   n_rise    = 0;
  int   cyc       = 0;
  int   glitches  = 0;
  logic prev_sclk = 1'b0;
  logic prev_dc   = 1'b0;
  logic prev_sdin = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (oled_sclk && !prev_sclk && n_rise < 256) begin
      rise_sdin[n_rise] <= oled_sdin;
      rise_dc[n_rise]   <= oled_dc;
      rise_cyc[n_rise]  <= cyc + 1;
      n_rise            <= n_rise + 1;
    end
    if (rst_n && oled_sclk && prev_sclk &&
        (oled_dc != prev_dc || oled_sdin != prev_sdin)) begin
      glitches <= glitches + 1;
    end
    prev_sclk <= oled_sclk;
    prev_dc   <= oled_dc;
    prev_sdin <= oled_sdin;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_init_check(input string nm);
    logic en, ei;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= INIT_EDGE; k++) begin
      wait_neg();
      en = (k >= NRST_EDGE);
      ei = (k >= INIT_EDGE);
      // {nrst, init_done, s_ready, busy, sclk}
      check($sformatf("%s_edge%0d", nm, k),
            {27'd0, oled_nrst, init_done, bus.s_ready, busy, oled_sclk},
            {27'd0, en, ei, ei, !ei, 1'b0});
    end
  endtask

  task automatic send_and_check(input logic [7:0] d, input logic dc, input logic hold,
                                input string nm);
    int base, acc, k, w;
    logic [7:0] got, dcs;
    bus.s_data  = d;
    bus.s_dc    = dc;
    bus.s_valid = 1'b1;
    w = 0;
    while (bus.s_ready !== 1'b1 && w < 400) begin
      wait_neg();
      w++;
    end
    check({nm, "_wait"}, w, 0);
    base = n_rise;
    wait_neg();
    acc = cyc;
    if (!hold) bus.s_valid = 1'b0;
    check({nm, "_first"}, {28'd0, oled_dc, oled_sdin, bus.s_ready, busy},
          {28'd0, dc, d[7], 1'b0, 1'b1});
    k = 0;
    while (bus.s_ready !== 1'b1 && k < 400) begin
      wait_neg();
      k++;
    end
    check({nm, "_shift_cycles"}, k, 16 * CLK_DIV);
    check({nm, "_rises"}, n_rise - base, 8);
    got = 8'd0;
    dcs = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (base + i < 256) begin
        got[7-i] = rise_sdin[base+i];
        dcs[i]   = rise_dc[base+i];
      end
    end
    check({nm, "_bits"}, {24'd0, got}, {24'd0, d});
    check({nm, "_dc"}, {24'd0, dcs}, {24'd0, {8{dc}}});
    if (base < 256) check({nm, "_lat"}, rise_cyc[base] - acc, CLK_DIV);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       hold;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int base, k, r0;
    tbl[0] = '{data: 8'hA5,        dc: 1'b0, hold: 1'b0};
    tbl[1] = '{data: DISPLAY_OFF,  dc: 1'b0, hold: 1'b1};
    tbl[2] = '{data: 8'hFF,        dc: 1'b1, hold: 1'b0};
    tbl[3] = '{data: 8'h00,        dc: 1'b1, hold: 1'b0};
    tbl[4] = '{data: 8'h81,        dc: 1'b0, hold: 1'b1};
    tbl[5] = '{data: 8'h7E,        dc: 1'b1, hold: 1'b0};

    bus.s_data  = 8'h00;
    bus.s_dc    = 1'b0;
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    // {nrst, dc, sclk, sdin, s_ready, init_done, busy}
    check("reset_vals", {25'd0, oled_nrst, oled_dc, oled_sclk, oled_sdin, bus.s_ready,
          init_done, busy}, 32'h0000_0001);
    repeat (2) wait_neg();

    // Byte offered during the power-up sequence must be held off, then sent
    bus.s_data  = 8'h3C;
    bus.s_dc    = 1'b0;
    bus.s_valid = 1'b1;
    do_init_check("init");
    check("init_no_sclk", n_rise, 0);
    send_and_check(8'h3C, 1'b0, 1'b0, "held_3c");

    for (int i = 0; i < 6; i++) begin
      send_and_check(tbl[i].data, tbl[i].dc, tbl[i].hold, $sformatf("tbl%0d", i));
    end
    repeat (3) wait_neg();

    // Reset in the middle of a byte
    bus.s_data  = 8'hA5;
    bus.s_dc    = 1'b1;
    bus.s_valid = 1'b1;
    k = 0;
    while (bus.s_ready !== 1'b1 && k < 100) begin
      wait_neg();
      k++;
    end
    base = n_rise;
    wait_neg();
    bus.s_valid = 1'b0;
    k = 0;
    while ((n_rise - base) < 3 && k < 100) begin
      wait_neg();
      k++;
    end
    check("mid_rises", n_rise - base, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_vals", {25'd0, oled_nrst, oled_dc, oled_sclk, oled_sdin, bus.s_ready,
          init_done, busy}, 32'h0000_0001);
    repeat (4) wait_neg();
    r0 = n_rise;
    do_init_check("reinit");
    check("reinit_no_sclk", n_rise, r0);
    send_and_check(DISPLAY_ON, 1'b1, 1'b0, "after_reset");

    check("sclk_high_changes", glitches, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
